// File: rtl/matrix_cps_instr_pkg.sv
// Shared types and instruction encodings for the matrix-extension offload decoder.
// Instruction patterns are matched as (instr & MASK) == PATTERN.
package matrix_cps_instr_pkg;

    localparam int unsigned DEC_ID_W = 4;

    localparam logic [31:0] MZERO_MASK   = 32'hFFFC_7FFF;
    localparam logic [31:0] MZERO_PAT    = 32'hF800_002B;
    localparam logic [31:0] LDST_MASK    = 32'hFE00_007F;
    localparam logic [31:0] MLD_PAT      = 32'h0400_002B;
    localparam logic [31:0] MST_PAT      = 32'h0600_002B;
    localparam logic [31:0] ARITH_MASK   = 32'hFF00_7FFF;
    localparam logic [31:0] FMMACC_H_PAT = 32'h8000_00AB;
    localparam logic [31:0] FMMACC_S_PAT = 32'h8000_012B;
    localparam logic [31:0] MMAQA_B_PAT  = 32'hE000_082B;
    localparam logic [31:0] MMADA_H_PAT  = 32'hE800_082B;
    localparam logic [31:0] MMASA_W_PAT  = 32'hF000_082B;
    localparam logic [4:0]  LDST_WIDTH_MAX = 5'd2;

    typedef enum logic [3:0] {
        OP_NONE     = 4'd0,
        OP_FMMACC_H = 4'd1,
        OP_FMMACC_S = 4'd2,
        OP_MMAQA_B  = 4'd3,
        OP_MMADA_H  = 4'd4,
        OP_MMASA_W  = 4'd5,
        OP_MZERO    = 4'd6,
        OP_MLD      = 4'd7,
        OP_MST      = 4'd8
    } op_e;

    typedef enum logic [1:0] {
        WIDTH_B = 2'd0,
        WIDTH_H = 2'd1,
        WIDTH_W = 2'd2
    } width_e;

    typedef struct packed {
        op_e                 op;
        width_e              width;
        logic [2:0]          md;
        logic [2:0]          ms1;
        logic [2:0]          ms2;
        logic [31:0]         rs1;
        logic [31:0]         rs2;
        logic [DEC_ID_W-1:0] id;
    } decoded_op_t;

endpackage

// File: rtl/matrix_dec_fifo.sv
// Decoded-op FIFO: DEPTH entries (power of two), push/pop/flush, head shown combinationally.
module matrix_dec_fifo
    import matrix_cps_instr_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        push,
    input  decoded_op_t push_data,
    input  logic        pop,
    output decoded_op_t head,
    output logic        full,
    output logic        empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    decoded_op_t      mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_en_s;
    logic             pop_en_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == '0);
    assign push_en_s = push && !full && !flush;
    assign pop_en_s  = pop && !empty && !flush;
    assign head      = mem_r[rd_ptr_r];

    // Pointer and occupancy tracking; flush wins over push/pop
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_en_s, pop_en_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage
    always_ff @(posedge clk) begin
        if (push_en_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/matrix_instr_decoder.sv
// Matrix-extension offload decoder: one-cycle accept/reject response, legal ops queued for issue.
// Optional MATRIX_DEC_PERF_CNT_EN adds saturating accept/reject counters.
module matrix_instr_decoder
    import matrix_cps_instr_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned ID_W  = DEC_ID_W
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            instr_valid_i,
    output logic            instr_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [ID_W-1:0] instr_id_i,
    input  logic [31:0]     rs1_i,
    input  logic [31:0]     rs2_i,
    output logic            resp_valid_o,
    output logic            resp_accept_o,
    output logic [ID_W-1:0] resp_id_o,
    output logic            issue_valid_o,
    input  logic            issue_ready_i,
    output op_e             issue_op_o,
    output logic [1:0]      issue_width_o,
    output logic [2:0]      issue_md_o,
    output logic [2:0]      issue_ms1_o,
    output logic [2:0]      issue_ms2_o,
    output logic [31:0]     issue_rs1_o,
    output logic [31:0]     issue_rs2_o,
    output logic [ID_W-1:0] issue_id_o
`ifdef MATRIX_DEC_PERF_CNT_EN
    ,
    output logic [31:0]     n_accept_o,
    output logic [31:0]     n_reject_o
`endif
);

    // op == OP_NONE marks an illegal instruction
    function automatic decoded_op_t decode_instr(input logic [31:0] instr,
                                                 input logic [31:0] rs1,
                                                 input logic [31:0] rs2,
                                                 input logic [DEC_ID_W-1:0] id);
        decoded_op_t d;
        d     = '0;
        d.rs1 = rs1;
        d.rs2 = rs2;
        d.id  = id;
        if ((instr & MZERO_MASK) == MZERO_PAT) begin
            d.op = OP_MZERO;
            d.md = instr[17:15];
        end else if (((instr & LDST_MASK) == MLD_PAT || (instr & LDST_MASK) == MST_PAT) &&
                     (instr[14:10] <= LDST_WIDTH_MAX)) begin
            d.op    = ((instr & LDST_MASK) == MST_PAT) ? OP_MST : OP_MLD;
            d.width = width_e'(instr[11:10]);
            d.md    = instr[9:7];
        end else begin
            d.md  = instr[17:15];
            d.ms1 = instr[20:18];
            d.ms2 = instr[23:21];
            case (instr & ARITH_MASK)
                FMMACC_H_PAT: begin d.op = OP_FMMACC_H; d.width = WIDTH_H; end
                FMMACC_S_PAT: begin d.op = OP_FMMACC_S; d.width = WIDTH_W; end
                MMAQA_B_PAT:  begin d.op = OP_MMAQA_B;  d.width = WIDTH_B; end
                MMADA_H_PAT:  begin d.op = OP_MMADA_H;  d.width = WIDTH_H; end
                MMASA_W_PAT:  begin d.op = OP_MMASA_W;  d.width = WIDTH_W; end
                default:      begin d.op = OP_NONE;     d.width = WIDTH_B; end
            endcase
        end
        return d;
    endfunction

    decoded_op_t     dec_s;
    decoded_op_t     head_s;
    logic            take_s;
    logic            legal_s;
    logic            full_s;
    logic            empty_s;
    logic            resp_valid_r;
    logic            resp_accept_r;
    logic [ID_W-1:0] resp_id_r;

    assign instr_ready_o = !full_s && !flush_i;
    assign take_s        = instr_valid_i && instr_ready_o;
    assign dec_s         = decode_instr(instr_i, rs1_i, rs2_i, DEC_ID_W'(instr_id_i));
    assign legal_s       = (dec_s.op != OP_NONE);

    matrix_dec_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .flush     (flush_i),
        .push      (take_s && legal_s),
        .push_data (dec_s),
        .pop       (issue_ready_i),
        .head      (head_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    // Response pulse one cycle after each take
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_valid_r  <= 1'b0;
            resp_accept_r <= 1'b0;
            resp_id_r     <= '0;
        end else if (take_s) begin
            resp_valid_r  <= 1'b1;
            resp_accept_r <= legal_s;
            resp_id_r     <= instr_id_i;
        end else begin
            resp_valid_r  <= 1'b0;
            resp_accept_r <= 1'b0;
            resp_id_r     <= '0;
        end
    end

    assign resp_valid_o  = resp_valid_r;
    assign resp_accept_o = resp_accept_r;
    assign resp_id_o     = resp_id_r;

    // Issue port: head fields are forced to zero while the FIFO is empty
    always_comb begin
        issue_valid_o = !empty_s;
        issue_op_o    = OP_NONE;
        issue_width_o = 2'd0;
        issue_md_o    = 3'd0;
        issue_ms1_o   = 3'd0;
        issue_ms2_o   = 3'd0;
        issue_rs1_o   = 32'd0;
        issue_rs2_o   = 32'd0;
        issue_id_o    = '0;
        if (!empty_s) begin
            issue_op_o    = head_s.op;
            issue_width_o = head_s.width;
            issue_md_o    = head_s.md;
            issue_ms1_o   = head_s.ms1;
            issue_ms2_o   = head_s.ms2;
            issue_rs1_o   = head_s.rs1;
            issue_rs2_o   = head_s.rs2;
            issue_id_o    = ID_W'(head_s.id);
        end else begin
            issue_op_o    = OP_NONE;
        end
    end

`ifdef MATRIX_DEC_PERF_CNT_EN
    logic [31:0] n_accept_r;
    logic [31:0] n_reject_r;

    // Saturating counters, updated together with the response register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            n_accept_r <= 32'd0;
            n_reject_r <= 32'd0;
        end else if (take_s && legal_s && (n_accept_r != 32'hFFFF_FFFF)) begin
            n_accept_r <= n_accept_r + 32'd1;
        end else if (take_s && !legal_s && (n_reject_r != 32'hFFFF_FFFF)) begin
            n_reject_r <= n_reject_r + 32'd1;
        end else begin
            n_accept_r <= n_accept_r;
            n_reject_r <= n_reject_r;
        end
    end

    assign n_accept_o = n_accept_r;
    assign n_reject_o = n_reject_r;
`endif

endmodule
